// File: rtl/avr_bus_master_pkg.sv
// Shared types and defaults for the AVR-side SRAM bus master and its CPLD peer.
package avr_bus_master_pkg;

  localparam int ADDR_W_DEF    = 21;
  localparam int OE_CYCLES_DEF = 3;
  localparam int WE_CYCLES_DEF = 2;

  // Master sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    DONE
  } state_t;

  // CPLD bus_fsm states, kept here so both sides share one definition.
  typedef enum logic [1:0] {
    CPLD_SHIFT,
    CPLD_LATCHED,
    CPLD_READ,
    CPLD_WRITE
  } cpld_state_t;

  // Counter width that covers the shift length and both strobe lengths.
  function automatic int cnt_width(input int aw, input int oe, input int we);
    int m;
    m = aw;
    if (oe > m) m = oe;
    if (we > m) m = we;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/avr_bus_master_sreg_tx.sv
// Parallel-load, MSB-first serializer feeding the CPLD address shift register.
module sreg_tx #(
  parameter int W     = 21,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         si,
  output logic         busy,
  output logic         done
);

  logic [W-1:0]     sh;
  logic [CNT_W-1:0] cnt;

  // Load the word, then shift left one bit per clock until W bits have gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= din;
      cnt <= CNT_W'(W);
    end else if (cnt != '0) begin
      sh  <= {sh[W-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  assign si   = sh[W-1];
  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/avr_bus_master.sv
// Command-driven SRAM bus master: shifts the address into the CPLD (skipped
// when the CPLD already holds it), then runs the read or write strobe sequence.
module avr_bus_master
  import avr_bus_master_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OE_CYCLES = OE_CYCLES_DEF,
  parameter int WE_CYCLES = WE_CYCLES_DEF
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              avr_si,
  output logic              avr_sreg_en,
  output logic              avr_oe,
  output logic              avr_we,
  output logic [7:0]        avr_data_out,
  output logic              avr_data_oe,
  input  logic [7:0]        avr_data_in
);

  localparam int CNT_W = cnt_width(ADDR_W, OE_CYCLES, WE_CYCLES);

  state_t            state, nxt;
  logic              init;
  logic              sreg_en_q;
  logic              shadow_vld;
  logic [ADDR_W-1:0] shadow_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [7:0]        wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, hit;
  logic              sh_si, sh_busy, sh_done;

  assign cmd_ready = (state == IDLE) && init;
  assign accept    = cmd_valid && cmd_ready;
  assign hit       = shadow_vld && (cmd_addr == shadow_addr);

  sreg_tx #(.W(ADDR_W), .CNT_W(CNT_W)) u_sreg (
    .clk  (avr_clk),
    .rst  (avr_reset),
    .load (accept && !hit),
    .din  (cmd_addr),
    .si   (sh_si),
    .busy (sh_busy),
    .done (sh_done)
  );

  // Next-state sequencing.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (accept) nxt = hit ? (cmd_write ? WR_SETUP : RD_STROBE) : SHIFT;
      SHIFT:     if (sh_done) nxt = LATCH;
      LATCH:     nxt = write_q ? WR_SETUP : RD_STROBE;
      RD_STROBE: if (cnt == '0) nxt = DONE;
      WR_SETUP:  nxt = WR_STROBE;
      WR_STROBE: if (cnt == '0) nxt = WR_HOLD;
      WR_HOLD:   nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Bus-side outputs decoded from the current state.
  always_comb begin
    avr_si       = 1'b0;
    avr_oe       = 1'b1;
    avr_we       = 1'b1;
    avr_data_oe  = 1'b0;
    avr_data_out = 8'h00;
    rsp_valid    = 1'b0;
    case (state)
      SHIFT:     avr_si = sh_busy & sh_si;
      RD_STROBE: avr_oe = 1'b0;
      WR_SETUP:  begin avr_data_oe = 1'b1; avr_data_out = wdata_q; end
      WR_STROBE: begin avr_data_oe = 1'b1; avr_data_out = wdata_q; avr_we = 1'b0; end
      WR_HOLD:   begin avr_data_oe = 1'b1; avr_data_out = wdata_q; end
      DONE:      rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  assign avr_sreg_en = sreg_en_q;

  // State, command capture, address shadow and strobe counter.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state       <= IDLE;
      init        <= 1'b0;
      sreg_en_q   <= 1'b0;
      shadow_vld  <= 1'b0;
      shadow_addr <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      cnt         <= '0;
      rsp_rdata   <= 8'h00;
    end else begin
      state <= nxt;
      init  <= 1'b1;
      if (accept) begin
        addr_q  <= cmd_addr;
        write_q <= cmd_write;
        wdata_q <= cmd_wdata;
      end
      // The CPLD register holds garbage while shifting, so the shadow is
      // dropped at the start of a shift and reloaded at the latch.
      if (nxt == SHIFT && state != SHIFT) begin
        sreg_en_q  <= 1'b0;
        shadow_vld <= 1'b0;
      end else if (nxt == LATCH) begin
        sreg_en_q   <= 1'b1;
        shadow_vld  <= 1'b1;
        shadow_addr <= addr_q;
      end
      if (nxt == RD_STROBE && state != RD_STROBE)
        cnt <= CNT_W'(OE_CYCLES - 1);
      else if (nxt == WR_STROBE && state != WR_STROBE)
        cnt <= CNT_W'(WE_CYCLES - 1);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == RD_STROBE && cnt == '0)
        rsp_rdata <= avr_data_in;
    end
  end

endmodule

// File: tb/tb_avr_bus_master.sv
// Directed bench for avr_bus_master with a CPLD shift-register model and an SRAM model.
module tb_avr_bus_master;

  localparam int AW  = 21;
  localparam int OEC = 3;
  localparam int WEC = 2;
  localparam int LAT_RD    = AW + OEC + 2;   // 26
  localparam int LAT_WR    = AW + WEC + 4;   // 27
  localparam int LAT_RD_HIT = OEC + 1;       // 4
  localparam int LAT_WR_HIT = WEC + 3;       // 5

  logic          avr_clk = 1'b0;
  logic          avr_reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_wdata = 8'h00;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          avr_si, avr_sreg_en, avr_oe, avr_we, avr_data_oe;
  logic [7:0]    avr_data_out;
  logic [7:0]    avr_data_in = 8'h00;

  avr_bus_master #(.ADDR_W(AW), .OE_CYCLES(OEC), .WE_CYCLES(WEC)) dut (
    .avr_clk(avr_clk), .avr_reset(avr_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .avr_si(avr_si), .avr_sreg_en(avr_sreg_en), .avr_oe(avr_oe), .avr_we(avr_we),
    .avr_data_out(avr_data_out), .avr_data_oe(avr_data_oe), .avr_data_in(avr_data_in)
  );

  always #5 avr_clk = ~avr_clk;

  int vectors = 0;
  int errs = 0;
  bit mon_en = 1'b0;

  // CPLD model: shifts si in while sreg_en is low, presents the word otherwise.
  logic [AW-1:0] cpld_sh = '0;
  always @(posedge avr_clk) if (avr_sreg_en === 1'b0) cpld_sh <= {cpld_sh[AW-2:0], avr_si};

  logic [7:0] sram    [logic [AW-1:0]];
  logic [7:0] exp_mem [logic [AW-1:0]];

  // Per-command observations.
  int         r_lat, r_nsreg0, r_noe, r_nwe, r_ndoe;
  logic [7:0] r_rd;
  bit         r_bad_dout, r_bad_ready, r_window;

  task automatic tick;
    @(posedge avr_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe safety on every cycle.
  always @(negedge avr_clk) if (mon_en) begin
    vectors += 2;
    assert (!(avr_oe === 1'b0 && avr_we === 1'b0)) else begin
      errs++; $error("FAIL strobe_overlap: oe=%b we=%b expected not both 0", avr_oe, avr_we);
    end
    assert (!((avr_oe === 1'b0 || avr_we === 1'b0) && avr_sreg_en !== 1'b1)) else begin
      errs++; $error("FAIL strobe_in_shift: oe=%b we=%b sreg_en=%b expected sreg_en 1", avr_oe, avr_we, avr_sreg_en);
    end
  end

  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [7:0] wd,
                         input logic [7:0] rdv, input bit use_model);
    int k, first_doe, last_doe, first_we, last_we;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin tick; k++; end
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    tick;
    // Scramble inputs after acceptance; the captured command must be used.
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
    r_lat = -1; r_nsreg0 = 0; r_noe = 0; r_nwe = 0; r_ndoe = 0;
    r_bad_dout = 0; r_bad_ready = 0;
    first_doe = -1; last_doe = -1; first_we = -1; last_we = -1;
    for (k = 1; k < 100; k++) begin
      if (cmd_ready !== 1'b0) r_bad_ready = 1;
      if (avr_sreg_en === 1'b0) r_nsreg0++;
      if (avr_data_oe === 1'b1) begin
        r_ndoe++;
        if (first_doe < 0) first_doe = k;
        last_doe = k;
        if (avr_data_out !== wd) r_bad_dout = 1;
      end
      if (avr_we === 1'b0) begin
        r_nwe++;
        if (first_we < 0) first_we = k;
        last_we = k;
        if (use_model) sram[cpld_sh] = avr_data_out;
      end
      if (avr_oe === 1'b0) begin
        r_noe++;
        if (use_model) avr_data_in = sram.exists(cpld_sh) ? sram[cpld_sh] : 8'h00;
        else           avr_data_in = (r_noe == OEC) ? rdv : ~rdv;
      end else begin
        avr_data_in = 8'h00;
      end
      if (rsp_valid === 1'b1) begin r_lat = k; break; end
      tick;
    end
    r_rd = rsp_rdata;
    r_window = (r_nwe == 0) || (first_doe >= 0 && first_doe < first_we && last_we < last_doe);
    tick;
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_si"},      {31'd0, avr_si},      32'd0);
    chk({tag, "_sreg_en"}, {31'd0, avr_sreg_en}, 32'd0);
    chk({tag, "_oe"},      {31'd0, avr_oe},      32'd1);
    chk({tag, "_we"},      {31'd0, avr_we},      32'd1);
    chk({tag, "_data_oe"}, {31'd0, avr_data_oe}, 32'd0);
    chk({tag, "_data_out"}, {24'd0, avr_data_out}, 32'd0);
    chk({tag, "_ready"},   {31'd0, cmd_ready},   32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] addrs [4];
    logic [AW-1:0] prev_a;
    logic [7:0]    d;
    bit            prev_v, rsp_seen;
    int            idx;

    // Reset state
    avr_reset = 1'b1;
    repeat (3) tick;
    chk_reset_outputs("rst");
    avr_reset = 1'b0;
    tick;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1'b1;

    // Shifted read
    run_cmd(0, 21'h1A5A5, 8'h00, 8'hAA, 0);
    chk("rd_lat", r_lat, LAT_RD);
    chk("rd_data", {24'd0, r_rd}, 32'hAA);
    chk("rd_shift_clocks", r_nsreg0, AW);
    chk("rd_si_pattern", {11'd0, cpld_sh}, 32'h1A5A5);
    chk("rd_oe_clocks", r_noe, OEC);
    chk("rd_data_oe", r_ndoe, 0);
    chk("rd_ready_busy", {31'd0, r_bad_ready}, 32'd0);

    // Shadow-hit read
    run_cmd(0, 21'h1A5A5, 8'h00, 8'hBB, 0);
    chk("hit_rd_lat", r_lat, LAT_RD_HIT);
    chk("hit_rd_no_shift", r_nsreg0, 0);
    chk("hit_rd_data", {24'd0, r_rd}, 32'hBB);

    // Shifted write
    run_cmd(1, 21'h00010, 8'hEE, 8'h00, 0);
    chk("wr_lat", r_lat, LAT_WR);
    chk("wr_data_oe_clocks", r_ndoe, 4);
    chk("wr_we_clocks", r_nwe, WEC);
    chk("wr_oe_clocks", r_noe, 0);
    chk("wr_data_out", {31'd0, r_bad_dout}, 32'd0);
    chk("wr_we_window", {31'd0, r_window}, 32'd1);
    chk("wr_addr", {11'd0, cpld_sh}, 32'h00010);
    chk("wr_rdata_held", {24'd0, r_rd}, 32'hBB);

    // Shadow-hit write
    run_cmd(1, 21'h00010, 8'h5C, 8'h00, 0);
    chk("hit_wr_lat", r_lat, LAT_WR_HIT);
    chk("hit_wr_no_shift", r_nsreg0, 0);
    chk("hit_wr_data_out", {31'd0, r_bad_dout}, 32'd0);

    // Neighbouring address forces a reshift
    run_cmd(0, 21'h1A5A5, 8'h00, 8'h3C, 0);
    chk("reshift_a_lat", r_lat, LAT_RD);
    run_cmd(0, 21'h1A5A6, 8'h00, 8'hC3, 0);
    chk("reshift_b_lat", r_lat, LAT_RD);
    chk("reshift_b_shift", r_nsreg0, AW);
    chk("reshift_b_addr", {11'd0, cpld_sh}, 32'h1A5A6);
    chk("reshift_b_data", {24'd0, r_rd}, 32'hC3);

    // Reset in the middle of a shift
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 21'h1A5A5;
    tick;
    cmd_valid = 1'b0;
    rsp_seen = 1'b0;
    repeat (10) begin
      if (rsp_valid === 1'b1) rsp_seen = 1'b1;
      tick;
    end
    avr_reset = 1'b1;
    tick;
    if (rsp_valid === 1'b1) rsp_seen = 1'b1;
    chk("midrst_sreg_en", {31'd0, avr_sreg_en}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("midrst_oe", {31'd0, avr_oe}, 32'd1);
    chk("midrst_rdata", {24'd0, rsp_rdata}, 32'd0);
    avr_reset = 1'b0;
    tick;
    if (rsp_valid === 1'b1) rsp_seen = 1'b1;
    chk("midrst_no_rsp", {31'd0, rsp_seen}, 32'd0);
    chk("midrst_ready_rise", {31'd0, cmd_ready}, 32'd1);
    run_cmd(0, 21'h1A5A5, 8'h00, 8'h77, 0);
    chk("midrst_reread_lat", r_lat, LAT_RD);
    chk("midrst_reread_shift", r_nsreg0, AW);
    chk("midrst_reread_data", {24'd0, r_rd}, 32'h77);

    // Reset while idle must also drop the shadow
    avr_reset = 1'b1; tick;
    avr_reset = 1'b0; tick;
    run_cmd(0, 21'h1A5A5, 8'h00, 8'h66, 0);
    chk("idlerst_lat", r_lat, LAT_RD);
    chk("idlerst_data", {24'd0, r_rd}, 32'h66);

    // Random stream through the CPLD and SRAM models
    for (int i = 0; i < 4; i++) addrs[i] = AW'($urandom);
    prev_a = 21'h1A5A5; prev_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      run_cmd(1, addrs[i], d, 8'h00, 1);
      exp_mem[addrs[i]] = d;
      chk("rnd_init_lat", r_lat, (prev_v && prev_a == addrs[i]) ? LAT_WR_HIT : LAT_WR);
      prev_a = addrs[i];
    end
    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        run_cmd(1, addrs[idx], d, 8'h00, 1);
        exp_mem[addrs[idx]] = d;
        chk("rnd_wr_lat", r_lat, (prev_a == addrs[idx]) ? LAT_WR_HIT : LAT_WR);
      end else begin
        run_cmd(0, addrs[idx], 8'h00, 8'h00, 1);
        chk("rnd_rd_lat", r_lat, (prev_a == addrs[idx]) ? LAT_RD_HIT : LAT_RD);
        chk("rnd_rd_data", {24'd0, r_rd}, {24'd0, exp_mem[addrs[idx]]});
      end
      chk("rnd_ready_busy", {31'd0, r_bad_ready}, 32'd0);
      prev_a = addrs[idx];
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
